bitwise_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit; next generation of the 16-bit inverter.

---
 rtl/bitwise_pkg.sv | 43 ++++
 rtl/skid_buffer.sv | 66 ++++++
 rtl/bitwise_pipe.sv | 107 ++++++++++
 tb/tb_bitwise_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Opcodes, accumulate-FSM encoding and the width-generic bitwise evaluator
// shared by the bitwise pipeline.
package bitwise_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned EVAL_W = 64;  // widest operand bitwise_eval can carry

   localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
   localparam logic [OP_W-1:0] OP_AND  = 3'd1;
   localparam logic [OP_W-1:0] OP_OR   = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_ACC  = 3'd7;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } acc_state_e;

   // Stateless ops only; OP_ACC is resolved against the accumulator by the caller.
   function automatic logic [EVAL_W-1:0] bitwise_eval(
      input logic [OP_W-1:0]   op,
      input logic [EVAL_W-1:0] a,
      input logic [EVAL_W-1:0] b
   );
      logic [EVAL_W-1:0] r;
      r = '0;
      case (op)
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// One-entry valid/ready register slice: an output register backed by a single
// skid entry so the upstream side can stream at full rate under backpressure.
module skid_buffer #(
   parameter int unsigned W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q,  out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q,  skid_data_d;
   logic         push_c;
   logic         load_c;

   assign in_ready_o  = ~skid_valid_q;
   assign push_c      = in_valid_i & ~skid_valid_q;
   // Output register may take new data when it is empty or being consumed.
   assign load_c      = ~out_valid_q | out_ready_i;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (load_c) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (push_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (push_c) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/bitwise_pipe.sv
// Registered WIDTH-generic bitwise logic unit with an XOR-accumulate mode,
// streaming results through a skid buffer for full throughput.
module bitwise_pipe
   import bitwise_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   localparam int unsigned PW = WIDTH + 1;

   acc_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             accept_c;
   logic             acc_beat_c;
   logic             push_c;
   logic [WIDTH-1:0] res_c;
   logic             res_last_c;
   logic [PW-1:0]    sb_out_c;

   assign accept_c   = in_valid & in_ready;
   assign acc_beat_c = accept_c & (in_op == OP_ACC);

   // Result path: stateless ops emit every beat, ACC only on its closing beat.
   always_comb begin
      res_c      = WIDTH'(bitwise_eval(in_op, EVAL_W'(in_a), EVAL_W'(in_b)));
      res_last_c = 1'b1;
      push_c     = accept_c;
      if (in_op == OP_ACC) begin
         res_c      = acc_q ^ in_a;
         res_last_c = 1'b1;
         push_c     = accept_c & in_last;
      end
   end

   // Accumulate FSM; non-ACC beats leave both state and accumulator untouched.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (acc_beat_c) begin
               if (in_last) begin
                  acc_d = ACC_INIT;
               end else begin
                  state_d = S_ACCUM;
                  acc_d   = acc_q ^ in_a;
               end
            end
         end
         S_ACCUM: begin
            if (acc_beat_c) begin
               if (in_last) begin
                  state_d = S_IDLE;
                  acc_d   = ACC_INIT;
               end else begin
                  acc_d = acc_q ^ in_a;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            acc_d   = ACC_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= ACC_INIT;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   skid_buffer #(
      .W(PW)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (push_c),
      .in_ready_o  (in_ready),
      .in_data_i   ({res_last_c, res_c}),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (sb_out_c)
   );

   assign out_last = sb_out_c[PW-1];
   assign out_data = sb_out_c[WIDTH-1:0];

endmodule

// File: tb/tb_bitwise_pipe.sv
// Bench for bitwise_pipe: three widths (1/16/32) share one stimulus stream and a
// queue-based reference model of accepted-but-unconsumed results.
module tb_bitwise_pipe;

   typedef struct {
      logic        last;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  in_op;
   logic [31:0] in_a, in_b;
   logic        in_last;
   logic        out_ready;

   logic        rdy16, ov16, ol16;
   logic [15:0] od16;
   logic        rdy1, ov1, ol1;
   logic [0:0]  od1;
   logic        rdy32, ov32, ol32;
   logic [31:0] od32;

   int          total = 0;
   int          bad   = 0;
   beat_t       q[$];
   logic [31:0] m_acc = 32'h0;

   always #5 clk = ~clk;

   bitwise_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
      .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_op(in_op), .in_last(in_last),
      .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .out_last(ol16));

   bitwise_pipe #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_op(in_op), .in_last(in_last),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1));

   bitwise_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
      .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_last(ol32));

   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0:    return ~a;
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a ^ b;
         3'd4:    return ~(a & b);
         3'd5:    return ~(a | b);
         3'd6:    return ~(a ^ b);
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock edge: consume the head, then accept a beat.
   task automatic model_step(input logic v, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic last, input logic ordy,
                             output logic took);
      beat_t nb;
      took = v && (q.size() < 2);
      if (ordy && q.size() > 0) q.delete(0);
      if (took) begin
         nb.last = 1'b1;
         if (op == 3'd7) begin
            if (last) begin
               nb.data = m_acc ^ a;
               q.push_back(nb);
               m_acc = 32'h0;
            end else begin
               m_acc = m_acc ^ a;
            end
         end else begin
            nb.data = ref_op(op, a, b);
            q.push_back(nb);
         end
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic last);
      in_valid = v;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_last  = last;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      total++;
      if (ov16 !== 1'b0 || od16 !== 16'h0 || ol16 !== 1'b0 || rdy16 !== 1'b1) begin
         bad++;
         $display("FAIL reset16 got v=%b d=%h l=%b r=%b want v=0 d=0000 l=0 r=1", ov16, od16, ol16, rdy16);
      end
      total++;
      if (ov1 !== 1'b0 || od1 !== 1'b0 || ol1 !== 1'b0 || rdy1 !== 1'b1) begin
         bad++;
         $display("FAIL reset1 got v=%b d=%h l=%b r=%b want v=0 d=0 l=0 r=1", ov1, od1, ol1, rdy1);
      end
      total++;
      if (ov32 !== 1'b0 || od32 !== 32'h0 || ol32 !== 1'b0 || rdy32 !== 1'b1) begin
         bad++;
         $display("FAIL reset32 got v=%b d=%h l=%b r=%b want v=0 d=0 l=0 r=1", ov32, od32, ol32, rdy32);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [2:0]  ops [4];
      logic [15:0] va [4];
      logic [15:0] vb [4];
      logic [15:0] ve [4];
      ops = '{3'd0, 3'd0, 3'd1, 3'd6};
      va  = '{16'h0000, 16'hA5A5, 16'hF0F0, 16'h1234};
      vb  = '{16'h0000, 16'h0000, 16'hFF00, 16'h1234};
      ve  = '{16'hFFFF, 16'h5A5A, 16'hF000, 16'hFFFF};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rdy16 !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready%0d got %b want 1", i, rdy16);
         end
         drive(1'b1, ops[i], 32'(va[i]), 32'(vb[i]), 1'b0);
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (ov16 !== 1'b1 || od16 !== ve[i] || ol16 !== 1'b1) begin
            bad++;
            $display("FAIL basic%0d got v=%b d=%h l=%b want v=1 d=%h l=1", i, ov16, od16, ol16, ve[i]);
         end
         @(negedge clk);
         total++;
         if (ov16 !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain%0d got v=%b want 0", i, ov16);
         end
      end
   endtask

   task automatic test_width_not();
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ov1 !== 1'b1 || od1 !== 1'b1 || ol1 !== 1'b1) begin
         bad++;
         $display("FAIL not_w1 got v=%b d=%h l=%b want v=1 d=1 l=1", ov1, od1, ol1);
      end
      total++;
      if (ov32 !== 1'b1 || od32 !== 32'hFFFF_FFFF || ol32 !== 1'b1) begin
         bad++;
         $display("FAIL not_w32 got v=%b d=%h l=%b want v=1 d=ffffffff l=1", ov32, od32, ol32);
      end
      @(negedge clk);
   endtask

   task automatic test_acc();
      logic [15:0] av [4];
      av = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'd7, 32'(av[i]), 32'h0, i == 3);
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (i < 3 && ov16 !== 1'b0) begin
            bad++;
            $display("FAIL acc_quiet%0d got v=%b want 0", i, ov16);
         end else if (i == 3 && (ov16 !== 1'b1 || od16 !== 16'hFFFF || ol16 !== 1'b1)) begin
            bad++;
            $display("FAIL acc_close got v=%b d=%h l=%b want v=1 d=ffff l=1", ov16, od16, ol16);
         end
      end
      @(negedge clk);
      drive(1'b1, 3'd7, 32'h0001, 32'h0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ov16 !== 1'b1 || od16 !== 16'h0001 || ol16 !== 1'b1) begin
         bad++;
         $display("FAIL acc_restart got v=%b d=%h l=%b want v=1 d=0001 l=1", ov16, od16, ol16);
      end
      @(negedge clk);
   endtask

   task automatic test_interleave();
      out_ready = 1'b1;
      drive(1'b1, 3'd7, 32'h00FF, 32'h0, 1'b0);
      @(negedge clk);
      total++;
      if (ov16 !== 1'b0) begin
         bad++;
         $display("FAIL mix_quiet got v=%b want 0", ov16);
      end
      drive(1'b1, 3'd3, 32'hAAAA, 32'h5555, 1'b0);
      @(negedge clk);
      total++;
      if (ov16 !== 1'b1 || od16 !== 16'hFFFF || ol16 !== 1'b1) begin
         bad++;
         $display("FAIL mix_xor got v=%b d=%h l=%b want v=1 d=ffff l=1", ov16, od16, ol16);
      end
      drive(1'b1, 3'd7, 32'hFF00, 32'h0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ov16 !== 1'b1 || od16 !== 16'hFFFF || ol16 !== 1'b1) begin
         bad++;
         $display("FAIL mix_acc got v=%b d=%h l=%b want v=1 d=ffff l=1", ov16, od16, ol16);
      end
      @(negedge clk);
      total++;
      if (ov16 !== 1'b0) begin
         bad++;
         $display("FAIL mix_drain got v=%b want 0", ov16);
      end
      drive(1'b1, 3'd7, 32'h0000, 32'h0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ov16 !== 1'b1 || od16 !== 16'h0000) begin
         bad++;
         $display("FAIL mix_init got v=%b d=%h want v=1 d=0000", ov16, od16);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic        pat [8];
      int          sent, got;
      logic        took, prev_stall;
      logic [15:0] prev_d;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      q.delete();
      m_acc = 32'h0;
      sent = 0;
      got = 0;
      took = 1'b1;
      prev_stall = 1'b0;
      prev_d = 16'h0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         total++;
         if (ov16 !== (q.size() > 0) || rdy16 !== (q.size() < 2) ||
             (q.size() > 0 && (od16 !== q[0].data[15:0] || ol16 !== 1'b1))) begin
            bad++;
            $display("FAIL b2b cyc=%0d got v=%b r=%b d=%h want v=%b r=%b d=%h", cyc, ov16, rdy16,
                     od16, q.size() > 0, q.size() < 2, q.size() > 0 ? q[0].data[15:0] : 16'h0);
         end
         if (prev_stall) begin
            total++;
            if (od16 !== prev_d) begin
               bad++;
               $display("FAIL b2b_hold cyc=%0d got d=%h want d=%h", cyc, od16, prev_d);
            end
         end
         if (!in_valid || took)
            drive(sent < 8, 3'd2, $urandom, $urandom, 1'($urandom));
         out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
         if (out_ready && q.size() > 0) got++;
         prev_stall = ov16 && !out_ready;
         prev_d = od16;
         model_step(in_valid, in_op, in_a, in_b, in_last, out_ready, took);
         if (took) sent++;
         @(negedge clk);
         if (sent >= 8) in_valid = 1'b0;
      end
      total++;
      if (got != 8) begin
         bad++;
         $display("FAIL b2b_timeout got %0d results want 8", got);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd7, 32'h1234, 32'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ov16 !== 1'b1 || od16 !== 16'hFFFF) begin
         bad++;
         $display("FAIL rstmid_pre got v=%b d=%h want v=1 d=ffff", ov16, od16);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (ov16 !== 1'b0 || od16 !== 16'h0 || ol16 !== 1'b0 || rdy16 !== 1'b1 ||
          ov32 !== 1'b0 || ov1 !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_clear got v=%b d=%h l=%b r=%b v32=%b v1=%b want v=0 d=0000 l=0 r=1",
                  ov16, od16, ol16, rdy16, ov32, ov1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 3'd7, 32'h0001, 32'h0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (ov16 !== 1'b1 || od16 !== 16'h0001 || ol16 !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_acc got v=%b d=%h l=%b want v=1 d=0001 l=1", ov16, od16, ol16);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int          beats;
      logic        took, ev, el, er;
      logic [31:0] ed;
      q.delete();
      m_acc = 32'h0;
      beats = 0;
      took = 1'b1;
      for (int cyc = 0; cyc < 20000 && (beats < 1000 || q.size() > 0); cyc++) begin
         ev = q.size() > 0;
         er = q.size() < 2;
         ed = ev ? q[0].data : 32'h0;
         el = ev ? q[0].last : 1'b0;
         total++;
         if (ov16 !== ev || rdy16 !== er || (ev && (od16 !== ed[15:0] || ol16 !== el))) begin
            bad++;
            $display("FAIL rand16 cyc=%0d got v=%b r=%b d=%h l=%b want v=%b r=%b d=%h l=%b",
                     cyc, ov16, rdy16, od16, ol16, ev, er, ed[15:0], el);
         end
         total++;
         if (ov1 !== ev || rdy1 !== er || (ev && (od1 !== ed[0:0] || ol1 !== el))) begin
            bad++;
            $display("FAIL rand1 cyc=%0d got v=%b r=%b d=%h l=%b want v=%b r=%b d=%h l=%b",
                     cyc, ov1, rdy1, od1, ol1, ev, er, ed[0], el);
         end
         total++;
         if (ov32 !== ev || rdy32 !== er || (ev && (od32 !== ed || ol32 !== el))) begin
            bad++;
            $display("FAIL rand32 cyc=%0d got v=%b r=%b d=%h l=%b want v=%b r=%b d=%h l=%b",
                     cyc, ov32, rdy32, od32, ol32, ev, er, ed, el);
         end
         if (!in_valid || took)
            drive(beats < 1000 && $urandom_range(3) != 0, 3'($urandom_range(7)), $urandom,
                  $urandom, $urandom_range(3) == 0);
         out_ready = (beats >= 1000) ? 1'b1 : ($urandom_range(9) < 6);
         model_step(in_valid, in_op, in_a, in_b, in_last, out_ready, took);
         if (took) beats++;
         @(negedge clk);
      end
      total++;
      if (beats != 1000 || q.size() != 0) begin
         bad++;
         $display("FAIL rand_timeout got beats=%0d pending=%0d want beats=1000 pending=0", beats, q.size());
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      test_reset();
      test_basic();
      test_width_not();
      test_acc();
      test_interleave();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
